corescore_stream_arbiter: RTL and testbench
===========================================

# corescore_stream_arbiter

Packet-granular round-robin arbiter that shares one byte-wide AXI-stream sink, the UART emitter, between N byte-stream sources such as multiple corescorecore instances or a debug/status source. A grant is held from the first beat of a packet to the beat carrying tlast, so packets are never interleaved. The block sits between the sources and the emitter and adds one registered output stage.

## Interface
- N, default 4: number of source streams, 2..16.
- IDXW, default $clog2(N): width of the grant index.
- i_clk in 1: single clock; all logic is rising-edge.
- i_rst_n in 1: asynchronous, active-low reset.
- i_tdata in N*8: source data; source k occupies bits [8k+7:8k].
- i_tlast in N: per-source end-of-packet flag.
- i_tvalid in N: per-source valid.
- o_tready out N: per-source ready.
- o_tdata out 8: arbitrated data to the sink.
- o_tlast out 1: arbitrated end-of-packet flag.
- o_tvalid out 1: arbitrated valid.
- i_tready in 1: sink ready.
- o_grant out N: one-hot current grant; all-zero when idle.
- o_active out 1: high while a packet is locked.

## Operation
- FSM has two states:
  - IDLE: no grant.
  - PKT: grant locked to source g.
- **In IDLE:**
  - If any i_tvalid is high, pick the first requester scanning from (last+1) mod N upward with wrap.
  - Register g and enter PKT on the next edge.
  - If no i_tvalid is high, stay in IDLE.
- **Accept rule in PKT:** o_tready[g] = (!o_tvalid || i_tready). All other o_tready bits are 0. In IDLE all o_tready bits are 0.
  - The path from i_tready to o_tready is combinational by design.
- **Input beat transfer:** occurs when i_tvalid[g] && o_tready[g].
  - Load o_tdata and o_tlast from source g.
  - Set o_tvalid=1.
- **Output register:**
  - o_tvalid clears when i_tready=1 and no new beat is transferred in that cycle.
  - o_* stays stable while o_tvalid && !i_tready, as the AXI-stream rules require.
- **End of packet:** a transferred beat with i_tlast[g]=1 sets last=g and returns the FSM to IDLE on the same edge. The output register still drains that beat normally.
- **Source stall:** if source g drops tvalid mid-packet, the grant is held indefinitely. There is no timeout and no fabricated tlast.
- A single-beat packet (tlast on its first beat) is legal.
- Non-granted sources may assert or drop tvalid freely. They are never acknowledged.
- **Reset:**
  - State goes to IDLE, last = N-1 so source 0 has first priority.
  - o_tvalid=0, o_tdata=0, o_tlast=0, o_grant=0, o_active=0, o_tready=0.
  - A reset mid-packet drops the partial packet. Downstream sees no further beats of it.

## Timing
- **Arbitration bubble:** requester valid in IDLE during cycle 0 gives grant at edge 1, first input transfer at edge 2, and o_tvalid=1 during cycle 2. Request-to-output latency is 2 cycles.
- **Steady state:** one beat per cycle while source and sink are both ready. This is full throughput within a packet.
- **Packet-to-packet gap:** the tlast transfer edge goes to IDLE, the next edge grants, the following edge transfers. That leaves one idle input cycle between packets, even for the same source.
- **Status outputs:** o_grant and o_active are registered and change only with the FSM.

## Structure
- No shared package is needed. State encoding and N-dependent widths are local parameters.
- One natural sub-module, corescore_rr_pick: a purely combinational rotating-priority picker.
  - Inputs: req[N], last[IDXW].
  - Outputs: gnt_idx[IDXW], any.
  - Implementation: double-width mask trick or a rotate-then-find-first-set.
- The top level holds the FSM, the grant register and the output register stage. It is instantiated in board tops between corescorecore instances and the emitter.

## Test plan
- **Single source, N=4:** source 2 sends 3 bytes 0x41,0x42,0x43 with tlast on 0x43, sink always ready. Sink sees exactly those bytes with o_tlast on the third. o_tvalid first rises 2 cycles after request. o_grant=4'b0100 during the packet.
- **Contention:** all four sources request continuously with 2-byte packets. Grant order after reset is 0,1,2,3,0. Packets are never interleaved. There is one idle input cycle between packets.
- **Sink backpressure:** i_tready toggles 1,0,0,1,... during a packet. o_tdata and o_tlast hold stable while o_tvalid && !i_tready. No beat is lost or duplicated, checked by byte-sequence scoreboard.
- **Mid-packet source stall:** source 1 drops tvalid for 20 cycles after its first beat while source 3 requests. Grant stays on 1 and source 3 gets o_tready=0 throughout. Source 3 is served only after source 1's tlast.
- **Reset mid-packet:** i_rst_n asserted asynchronously (between clock edges) during beat 2 of a 5-beat packet. All outputs go to 0 immediately, without waiting for a clock edge. After release, source 0 wins first against sources 0 and 1 requesting together.
- **Edge cases:**
  - A single-beat packet yields o_tlast on its only byte.
  - With N=2, alternating grant across 10 packets from both sources.

Source files
------------

// File: rtl/corescore_stream_arbiter_pkg.sv
// Shared types for the packet-granular stream arbiter.
package corescore_stream_arbiter_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PKT  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/corescore_stream_arbiter_rr_pick.sv
// Combinational rotating-priority picker: first requester at or after last+1, wrapping.
module corescore_rr_pick #(
  parameter int N    = 4,
  parameter int IDXW = $clog2(N)
) (
  input  logic [N-1:0]    req_i,
  input  logic [IDXW-1:0] last_i,
  output logic [IDXW-1:0] gnt_idx_o,
  output logic            any_o
);

  // Walk from the farthest candidate to the nearest so the nearest one wins.
  always_comb begin
    gnt_idx_o = '0;
    any_o     = 1'b0;
    for (int off = N; off >= 1; off--) begin
      if (req_i[(int'(last_i) + off) % N]) begin
        gnt_idx_o = IDXW'((int'(last_i) + off) % N);
        any_o     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/corescore_stream_arbiter.sv
// Round-robin arbiter sharing one byte-wide AXI-stream sink between N sources,
// locking the grant for a whole packet and adding one registered output stage.
//
//   state   | meaning
//   --------+--------------------------------------------
//   ST_IDLE | no grant; picking next requester after last
//   ST_PKT  | grant locked to source g_q until its tlast beat
module corescore_stream_arbiter
  import corescore_stream_arbiter_pkg::*;
#(
  parameter int N    = 4,
  parameter int IDXW = $clog2(N)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [N*BYTE_W-1:0]   i_tdata,
  input  logic [N-1:0]          i_tlast,
  input  logic [N-1:0]          i_tvalid,
  output logic [N-1:0]          o_tready,
  output logic [BYTE_W-1:0]     o_tdata,
  output logic                  o_tlast,
  output logic                  o_tvalid,
  input  logic                  i_tready,
  output logic [N-1:0]          o_grant,
  output logic                  o_active
);

  arb_state_e        state_q;
  logic [IDXW-1:0]   g_q;
  logic [IDXW-1:0]   last_q;
  logic [N-1:0]      grant_q;
  logic              active_q;
  logic [BYTE_W-1:0] tdata_q;
  logic              tlast_q;
  logic              tvalid_q;

  logic [IDXW-1:0]   pick_idx;
  logic              pick_any;
  logic              accept;
  logic              xfer;
  logic [BYTE_W-1:0] sel_data;
  logic              sel_last;

  corescore_rr_pick #(
    .N    (N),
    .IDXW (IDXW)
  ) u_pick (
    .req_i     (i_tvalid),
    .last_i    (last_q),
    .gnt_idx_o (pick_idx),
    .any_o     (pick_any)
  );

  // Sink ready feeds straight through to the granted source's ready.
  assign accept = (state_q == ST_PKT) && (!tvalid_q || i_tready);

  always_comb begin
    o_tready = '0;
    sel_data = '0;
    sel_last = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (g_q == IDXW'(k)) begin
        o_tready[k] = accept;
        sel_data    = i_tdata[BYTE_W*k +: BYTE_W];
        sel_last    = i_tlast[k];
      end
    end
  end

  assign xfer = |(o_tready & i_tvalid);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      g_q      <= '0;
      last_q   <= IDXW'(N - 1);
      grant_q  <= '0;
      active_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pick_any) begin
            state_q  <= ST_PKT;
            g_q      <= pick_idx;
            grant_q  <= {{(N-1){1'b0}}, 1'b1} << pick_idx;
            active_q <= 1'b1;
          end
        end
        ST_PKT: begin
          if (xfer && sel_last) begin
            state_q  <= ST_IDLE;
            last_q   <= g_q;
            grant_q  <= '0;
            active_q <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tdata_q  <= '0;
      tlast_q  <= 1'b0;
      tvalid_q <= 1'b0;
    end else if (xfer) begin
      tdata_q  <= sel_data;
      tlast_q  <= sel_last;
      tvalid_q <= 1'b1;
    end else if (i_tready) begin
      tvalid_q <= 1'b0;
    end
  end

  assign o_tdata  = tdata_q;
  assign o_tlast  = tlast_q;
  assign o_tvalid = tvalid_q;
  assign o_grant  = grant_q;
  assign o_active = active_q;

endmodule

// File: tb/tb_corescore_stream_arbiter.sv
// Self-checking bench: directed vector table, corner-case sequences and a
// randomized run checked against a packet-level scoreboard of the arbiter rules.
module tb_corescore_stream_arbiter;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N*8-1:0] i_tdata;
  logic [N-1:0]   i_tlast, i_tvalid, o_tready, o_grant;
  logic           i_tready, o_tlast, o_tvalid, o_active;
  logic [7:0]     o_tdata;

  logic [15:0] t2_tdata;
  logic [1:0]  t2_tlast, t2_tvalid, o2_tready, o2_grant;
  logic        t2_tready, o2_tlast, o2_tvalid, o2_active;
  logic [7:0]  o2_tdata;

  corescore_stream_arbiter #(.N(N)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .o_tready(o_tready),
    .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .i_tready(i_tready),
    .o_grant(o_grant), .o_active(o_active)
  );

  corescore_stream_arbiter #(.N(2)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_tdata(t2_tdata), .i_tlast(t2_tlast), .i_tvalid(t2_tvalid), .o_tready(o2_tready),
    .o_tdata(o2_tdata), .o_tlast(o2_tlast), .o_tvalid(o2_tvalid), .i_tready(t2_tready),
    .o_grant(o2_grant), .o_active(o2_active)
  );

  int n_err = 0;
  int n_chk = 0;

  typedef struct {
    logic [7:0] d;
    logic       l;
  } beat_t;

  typedef struct {
    logic [3:0] vld;
    logic       lst;
    logic [7:0] dat;
    logic       rdy;
    logic [3:0] e_trdy;
    logic [3:0] e_grant;
    logic       e_v;
    logic [7:0] e_d;
    logic       e_l;
  } vec_t;

  beat_t exp_q[$];
  int    glog[$];
  int    log2[$];
  int    last_m, open_src, in_beats, out_beats;
  bit    open_m, mon_en, use_gen;
  int    g_cnt[N];
  int    g_rem[N];
  int    g_fixlen;

  logic [N-1:0]   s_vld, s_trdy, s_grant, s_tlast;
  logic [N*8-1:0] s_tdata;
  logic           s_rdy, s_ov, s_ol;
  logic [7:0]     s_od;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rr_ref(input logic [N-1:0] v, input int last);
    for (int off = 1; off <= N; off++)
      if (v[(last + off) % N]) return (last + off) % N;
    return -1;
  endfunction

  task automatic model_reset();
    last_m = N - 1;
    open_m = 1'b0;
    open_src = 0;
    exp_q.delete();
    glog.delete();
    in_beats = 0;
    out_beats = 0;
    for (int k = 0; k < N; k++) g_rem[k] = 0;
  endtask

  task automatic gen_drive();
    for (int k = 0; k < N; k++) begin
      if (g_rem[k] == 0) g_rem[k] = (g_fixlen != 0) ? g_fixlen : int'($urandom_range(1, 4));
      i_tdata[8*k +: 8] = 8'((k << 6) | (g_cnt[k] & 63));
      i_tlast[k] = (g_rem[k] == 1);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    i_tvalid = '0; i_tready = 1'b0; i_tdata = '0; i_tlast = '0;
    t2_tvalid = '0; t2_tready = 1'b0; t2_tdata = '0; t2_tlast = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // One clock: snapshot the pre-edge view, let the edge happen, check the result.
  task automatic cycle();
    int k, p, gi;
    logic [N-1:0] xfer, eg;
    beat_t b;
    if (use_gen) gen_drive();
    #1;
    s_vld = i_tvalid; s_trdy = o_tready; s_rdy = i_tready; s_ov = o_tvalid;
    s_od = o_tdata; s_ol = o_tlast; s_grant = o_grant; s_tdata = i_tdata; s_tlast = i_tlast;
    if (mon_en) begin
      chk("grant_onehot", 32'($countones(s_grant) <= 1), 1);
      chk("tready_rule", 32'(s_trdy), 32'((s_grant != 0 && (!s_ov || s_rdy)) ? s_grant : '0));
    end
    @(posedge clk);
    @(negedge clk);
    xfer = s_trdy & s_vld;
    k = -1;
    for (int j = 0; j < N; j++) if (xfer[j]) k = j;
    if (mon_en) begin
      if (s_ov && s_rdy) begin
        out_beats++;
        if (exp_q.size() == 0) chk("spurious_out_beat", 0, 1);
        else begin
          b = exp_q.pop_front();
          chk("out_data", 32'(s_od), 32'(b.d));
          chk("out_last", 32'(s_ol), 32'(b.l));
        end
      end
      if (s_ov && !s_rdy) begin
        chk("hold_valid", 32'(o_tvalid), 1);
        chk("hold_data", 32'(o_tdata), 32'(s_od));
        chk("hold_last", 32'(o_tlast), 32'(s_ol));
      end
      if (k >= 0) begin
        b.d = s_tdata[8*k +: 8];
        b.l = s_tlast[k];
        exp_q.push_back(b);
        in_beats++;
        if (open_m) chk("no_interleave", 32'(k), 32'(open_src));
        open_m = !s_tlast[k];
        open_src = k;
      end
      chk("o_tvalid", 32'(o_tvalid), (k >= 0) ? 1 : (s_rdy ? 0 : 32'(s_ov)));
      p = -1;
      if (s_grant == 0) begin
        p = rr_ref(s_vld, last_m);
        eg = (p < 0) ? '0 : (N'(1) << p);
      end else if (k >= 0 && s_tlast[k]) begin
        eg = '0;
        last_m = k;
      end else begin
        eg = s_grant;
      end
      chk("o_grant", 32'(o_grant), 32'(eg));
      chk("o_active", 32'(o_active), 32'(eg != 0));
      if (s_grant == 0 && o_grant != 0) begin
        gi = -1;
        for (int j = 0; j < N; j++) if (o_grant[j]) gi = j;
        glog.push_back(gi);
      end
    end
    if (k >= 0) begin
      g_cnt[k]++;
      g_rem[k]--;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  vec_t tbl[5];

  initial begin
    int prev2;
    for (int k = 0; k < N; k++) g_cnt[k] = 0;
    g_fixlen = 0;
    mon_en = 1'b1;
    use_gen = 1'b0;
    do_reset();

    // reset state
    chk("rst_tvalid", 32'(o_tvalid), 0);
    chk("rst_tdata", 32'(o_tdata), 0);
    chk("rst_grant", 32'(o_grant), 0);
    chk("rst_active", 32'(o_active), 0);
    chk("rst_tready", 32'(o_tready), 0);

    // single source 2 sends 0x41 0x42 0x43
    tbl[0] = '{4'b0100, 1'b0, 8'h41, 1'b1, 4'b0000, 4'b0100, 1'b0, 8'h00, 1'b0};
    tbl[1] = '{4'b0100, 1'b0, 8'h41, 1'b1, 4'b0100, 4'b0100, 1'b1, 8'h41, 1'b0};
    tbl[2] = '{4'b0100, 1'b0, 8'h42, 1'b1, 4'b0100, 4'b0100, 1'b1, 8'h42, 1'b0};
    tbl[3] = '{4'b0100, 1'b1, 8'h43, 1'b1, 4'b0100, 4'b0000, 1'b1, 8'h43, 1'b1};
    tbl[4] = '{4'b0000, 1'b0, 8'h00, 1'b1, 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0};
    for (int i = 0; i < 5; i++) begin
      i_tvalid = tbl[i].vld;
      i_tdata = '0;
      i_tdata[23:16] = tbl[i].dat;
      i_tlast = {1'b0, tbl[i].lst, 2'b00};
      i_tready = tbl[i].rdy;
      cycle();
      chk($sformatf("tbl%0d_tready", i), 32'(s_trdy), 32'(tbl[i].e_trdy));
      chk($sformatf("tbl%0d_grant", i), 32'(o_grant), 32'(tbl[i].e_grant));
      chk($sformatf("tbl%0d_tvalid", i), 32'(o_tvalid), 32'(tbl[i].e_v));
      if (tbl[i].e_v) begin
        chk($sformatf("tbl%0d_tdata", i), 32'(o_tdata), 32'(tbl[i].e_d));
        chk($sformatf("tbl%0d_tlast", i), 32'(o_tlast), 32'(tbl[i].e_l));
      end
    end
    use_gen = 1'b1;

    // contention: all four sources, 2-byte packets
    do_reset();
    g_fixlen = 2;
    i_tvalid = 4'hF;
    i_tready = 1'b1;
    repeat (15) cycle();
    chk("contend_beats", 32'(in_beats), 10);
    chk("contend_grants", 32'(glog.size()), 5);
    for (int i = 0; i < 5; i++)
      if (i < glog.size()) chk($sformatf("contend_order%0d", i), 32'(glog[i]), 32'(i % N));

    // sink backpressure 1,0,0 pattern
    do_reset();
    g_fixlen = 5;
    i_tvalid = 4'b0001;
    for (int i = 0; i < 40; i++) begin
      i_tready = (i % 3 == 0);
      cycle();
    end
    i_tvalid = '0;
    i_tready = 1'b1;
    repeat (3) cycle();
    chk("bp_drained", 32'(exp_q.size()), 0);
    chk("bp_in_eq_out", 32'(out_beats), 32'(in_beats));
    chk("bp_progress", 32'(in_beats >= 5), 1);

    // mid-packet stall of source 1 while source 3 requests
    do_reset();
    g_fixlen = 3;
    i_tvalid = 4'b1010;
    i_tready = 1'b1;
    for (int t = 0; t < 10 && in_beats < 1; t++) cycle();
    chk("stall_first_beat", 32'(in_beats), 1);
    for (int t = 0; t < 20; t++) begin
      i_tvalid = 4'b1000;
      cycle();
      chk("stall_grant", 32'(o_grant), 32'(4'b0010));
      chk("stall_src3_ready", 32'(s_trdy[3]), 0);
    end
    i_tvalid = 4'b1010;
    for (int t = 0; t < 20 && o_grant != 4'b1000; t++) cycle();
    chk("stall_src3_served", 32'(o_grant), 32'(4'b1000));
    chk("stall_src1_done", 32'(in_beats), 3);
    chk("stall_grant_log", 32'(glog.size()), 2);
    if (glog.size() >= 2) chk("stall_order", 32'(glog[0] * 16 + glog[1]), 32'(1 * 16 + 3));

    // reset mid-packet of a 5-beat packet
    do_reset();
    g_fixlen = 5;
    i_tvalid = 4'b0001;
    i_tready = 1'b1;
    for (int t = 0; t < 10 && in_beats < 2; t++) cycle();
    chk("mr_beat2_out", 32'(o_tvalid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_tvalid", 32'(o_tvalid), 0);
    chk("mr_tdata", 32'(o_tdata), 0);
    chk("mr_tlast", 32'(o_tlast), 0);
    chk("mr_grant", 32'(o_grant), 0);
    chk("mr_active", 32'(o_active), 0);
    chk("mr_tready", 32'(o_tready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    i_tvalid = 4'b0011;
    cycle();
    chk("mr_src0_first", 32'(o_grant), 32'(4'b0001));
    repeat (10) cycle();

    // randomized traffic
    do_reset();
    g_fixlen = 0;
    for (int i = 0; i < 3000; i++) begin
      i_tvalid = 4'($urandom);
      i_tready = ($urandom_range(0, 9) < 7);
      cycle();
    end
    i_tvalid = '0;
    i_tready = 1'b1;
    repeat (5) cycle();
    chk("rand_drained", 32'(exp_q.size()), 0);

    // N=2: single-beat packets from both sources alternate
    do_reset();
    t2_tvalid = 2'b11;
    t2_tlast = 2'b11;
    t2_tdata = 16'hB1B0;
    t2_tready = 1'b1;
    prev2 = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (prev2 == 0 && o2_grant != 0) log2.push_back(int'(o2_grant == 2'b10));
      if (o2_tvalid) chk("n2_tlast", 32'(o2_tlast), 1);
      prev2 = int'(o2_grant);
    end
    chk("n2_count", 32'(log2.size() >= 10), 1);
    for (int i = 0; i < 10; i++)
      if (i < log2.size()) chk($sformatf("n2_alt%0d", i), 32'(log2[i]), 32'(i % 2));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
